// File: rtl/log2_arb_pkg.sv
// Shared widths and the tag record that rides alongside each operand through the log2 core.
// Optional LOG2_ARB_ZERO_FLAG_EN adds a zero-operand bit to the tag.
package log2_arb_pkg;
  localparam int LOG2_DIN_W    = 24;
  localparam int LOG2_DOUT_W   = 8;
  localparam int LOG2_CORE_LAT = 3;
  localparam int LOG2_MAX_IDW  = 4;  // wide enough for up to 16 requesters

  typedef struct packed {
    logic                    valid;
`ifdef LOG2_ARB_ZERO_FLAG_EN
    logic                    zero;
`endif
    logic [LOG2_MAX_IDW-1:0] id;
  } log2_tag_t;
endpackage

// File: rtl/log2_arbiter_if.sv
// Requester/response bundle for log2_arbiter; master = requesters + result consumer, slave = arbiter.
// Optional LOG2_ARB_ZERO_FLAG_EN adds resp_zero.
interface log2_arbiter_if
  import log2_arb_pkg::*;
#(parameter int NREQ = 4);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0][LOG2_DIN_W-1:0] req_data;
  logic [NREQ-1:0]                 req_ready;
  logic                            resp_valid;
  logic [IDW-1:0]                  resp_id;
  logic [LOG2_DOUT_W-1:0]          resp_data;

`ifdef LOG2_ARB_ZERO_FLAG_EN
  logic resp_zero;
  modport master (output req_valid, req_data,
                  input  req_ready, resp_valid, resp_id, resp_data, resp_zero);
  modport slave  (input  req_valid, req_data,
                  output req_ready, resp_valid, resp_id, resp_data, resp_zero);
`else
  modport master (output req_valid, req_data,
                  input  req_ready, resp_valid, resp_id, resp_data);
  modport slave  (input  req_valid, req_data,
                  output req_ready, resp_valid, resp_id, resp_data);
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational search from the pointer, pointer moves past the winner
// only when a grant is actually issued.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);
  localparam int            IW   = $clog2(N);
  localparam logic [IW:0]   NW   = (IW+1)'(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  logic [IW-1:0] ptr;
  logic [IW:0]   idx;
  logic          found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= NW) idx = idx - NW;
      if (!found && req[idx[IW-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[IW-1:0];
      end
    end
    if (found && en && !rst) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr <= '0;
    else if (|gnt)  ptr <= (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
  end
endmodule

// File: rtl/log2_arbiter.sv
// Shares one pipelined log2 core among NREQ requesters; ids ride a tag pipe matched to CORE_LAT.
// Optional LOG2_ARB_ZERO_FLAG_EN flags responses whose operand was zero.
module log2_arbiter
  import log2_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CORE_LAT = LOG2_CORE_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  log2_arbiter_if.slave          bus,
  output logic [LOG2_DIN_W-1:0]  core_din,
  input  logic [LOG2_DOUT_W-1:0] core_dout,
  output logic                   busy
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]                gnt;
  logic [IDW-1:0]                 gnt_id;
  logic                           xfer;
  log2_tag_t                      tag_in, tag_out;
  log2_tag_t [CORE_LAT-1:0]       tag_pipe;
  logic                           any_vld;
  logic                           resp_v;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (bus.req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.req_ready = gnt;
  assign xfer          = |gnt;
  // Straight into the core: it registers the operand itself.
  assign core_din      = xfer ? bus.req_data[gnt_id] : '0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = xfer;
    tag_in.id    = LOG2_MAX_IDW'(gnt_id);
`ifdef LOG2_ARB_ZERO_FLAG_EN
    tag_in.zero  = xfer && (bus.req_data[gnt_id] == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int k = 1; k < CORE_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_comb begin
    any_vld = 1'b0;
    for (int k = 0; k < CORE_LAT; k++) any_vld = any_vld | tag_pipe[k].valid;
  end

  // Outputs read as idle while rst is high so in-flight results are dropped cleanly.
  assign busy           = any_vld & ~rst;
  assign tag_out        = tag_pipe[CORE_LAT-1];
  assign resp_v         = tag_out.valid & ~rst;
  assign bus.resp_valid = resp_v;
  assign bus.resp_id    = resp_v ? IDW'(tag_out.id) : '0;
  assign bus.resp_data  = resp_v ? core_dout : '0;
`ifdef LOG2_ARB_ZERO_FLAG_EN
  assign bus.resp_zero  = resp_v & tag_out.zero;
`endif
endmodule

// File: tb/tb_log2_arbiter.sv
// Bench for log2_arbiter: directed vector table plus hand sequences, with a 3-cycle log2 core model.
// Checks resp_zero when LOG2_ARB_ZERO_FLAG_EN is defined.
module tb_log2_arbiter;
  import log2_arb_pkg::*;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [23:0] core_din;
  logic [7:0]  core_dout;
  logic        busy;
  logic [7:0]  c1, c2, c3;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] op [NREQ];

  log2_arbiter_if #(.NREQ(NREQ)) bus ();

  log2_arbiter #(.NREQ(NREQ), .CORE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus.slave),
    .core_din(core_din), .core_dout(core_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Input is unsigned Q16.8; result is log2 clamped to 0..15 with a 4-bit truncated fraction.
  function automatic logic [7:0] ref_log2(input logic [23:0] x);
    int m;
    m = -1;
    for (int b = 0; b < 24; b++) if (x[b]) m = b;
    if (m < 8) return 8'h00;
    return {4'(m - 8), x[m-1 -: 4]};
  endfunction

  always @(posedge clk) begin
    c1 <= ref_log2(core_din);
    c2 <= c1;
    c3 <= c2;
  end
  assign core_dout = c3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       en;
    logic [3:0] ready;
    logic       rv;
    logic [1:0] rid;
    logic [7:0] rdata;
    logic       busy;
  } vec_t;
  vec_t tbl [19];

  task automatic run_table();
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd0, 8'h00, 1'b1};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd1, 8'h18, 1'b1};
    tbl[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd2, 8'hF0, 1'b1};
    tbl[6]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd3, 8'h82, 1'b1};
    tbl[7]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd0, 8'h00, 1'b1};
    tbl[8]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h18, 1'b1};
    tbl[9]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd2, 8'hF0, 1'b1};
    tbl[10] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h82, 1'b1};
    tbl[11] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[12] = '{4'h2, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[13] = '{4'hA, 1'b1, 4'b1000, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[14] = '{4'h2, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[15] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h18, 1'b1};
    tbl[16] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h82, 1'b1};
    tbl[17] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h18, 1'b1};
    tbl[18] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    for (int r = 0; r < 19; r++) begin
      bus.req_valid = tbl[r].valid;
      en = tbl[r].en;
      @(negedge clk);
      chk($sformatf("row%0d.ready", r), 32'(bus.req_ready), 32'(tbl[r].ready));
      chk($sformatf("row%0d.rv", r),    32'(bus.resp_valid), 32'(tbl[r].rv));
      chk($sformatf("row%0d.rid", r),   32'(bus.resp_id), 32'(tbl[r].rid));
      chk($sformatf("row%0d.rdata", r), 32'(bus.resp_data), 32'(tbl[r].rdata));
      chk($sformatf("row%0d.busy", r),  32'(busy), 32'(tbl[r].busy));
      next_cyc();
    end
  endtask

  task automatic run_random();
    logic [3:0]  pend;
    logic [23:0] dat [NREQ];
    int          waits [NREQ];
    int          mp;
    logic        mv [LAT];
    logic [1:0]  mid [LAT];
    logic [7:0]  md [LAT];
    logic        found, e;
    int          g;
    logic [3:0]  exp_rdy;
    pend = '0;
    mp = 0;
    for (int i = 0; i < NREQ; i++) begin waits[i] = 0; dat[i] = '0; end
    for (int s = 0; s < LAT; s++) begin mv[s] = 1'b0; mid[s] = '0; md[s] = '0; end
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && (i == 1 || $urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          dat[i] = 24'($urandom()) >> $urandom_range(0, 20);
        end
      e = ($urandom_range(0, 9) != 0);
      bus.req_valid = pend;
      en = e;
      for (int i = 0; i < NREQ; i++) bus.req_data[i] = dat[i];
      found = 1'b0;
      g = 0;
      if (e)
        for (int k = 0; k < NREQ; k++)
          if (!found && pend[(mp + k) % NREQ]) begin found = 1'b1; g = (mp + k) % NREQ; end
      exp_rdy = found ? 4'(1 << g) : 4'h0;
      @(negedge clk);
      chk("rnd.ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rnd.rv", 32'(bus.resp_valid), 32'(mv[LAT-1]));
      if (mv[LAT-1]) begin
        chk("rnd.rid", 32'(bus.resp_id), 32'(mid[LAT-1]));
        chk("rnd.rdata", 32'(bus.resp_data), 32'(md[LAT-1]));
      end
      chk("rnd.busy", 32'(busy), 32'(mv[0] | mv[1] | mv[2]));
      for (int s = LAT - 1; s > 0; s--) begin
        mv[s] = mv[s-1]; mid[s] = mid[s-1]; md[s] = md[s-1];
      end
      mv[0] = found;
      mid[0] = 2'(g);
      md[0] = ref_log2(dat[g]);
      if (found) begin
        chk("rnd.starve", 32'(waits[g] <= NREQ - 1), 32'd1);
        for (int i = 0; i < NREQ; i++) if (pend[i] && i != g) waits[i]++;
        waits[g] = 0;
        pend[g] = 1'b0;
        mp = (g + 1) % NREQ;
      end
      next_cyc();
    end
    bus.req_valid = '0;
    repeat (LAT + 1) next_cyc();
  endtask

  initial begin
    op[0] = 24'h000100;
    op[1] = 24'h000300;
    op[2] = 24'h800000;
    op[3] = 24'h012345;
    for (int i = 0; i < NREQ; i++) bus.req_data[i] = op[i];

    // Reset state, with every requester asking
    rst = 1'b1; en = 1'b1; bus.req_valid = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 0);
    chk("rst.rv", 32'(bus.resp_valid), 0);
    chk("rst.rid", 32'(bus.resp_id), 0);
    chk("rst.rdata", 32'(bus.resp_data), 0);
    chk("rst.busy", 32'(busy), 0);
    next_cyc();
    rst = 1'b0;

    run_table();

    // Single request from requester 2
    do_reset();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single.ready", 32'(bus.req_ready), 32'h4);
    chk("single.din", 32'(core_din), 32'h800000);
    next_cyc();
    bus.req_valid = '0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      chk($sformatf("single.rv%0d", t), 32'(bus.resp_valid), 32'(t == 3));
      chk($sformatf("single.busy%0d", t), 32'(busy), 32'(t <= 3));
      if (t == 3) begin
        chk("single.rid", 32'(bus.resp_id), 2);
        chk("single.rdata", 32'(bus.resp_data), 32'hF0);
      end
      next_cyc();
    end

    // en low with three in flight: results drain, pointer holds
    do_reset();
    bus.req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall.pre%0d", c), 32'(bus.req_ready), 32'(1 << c));
      next_cyc();
    end
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall.ready%0d", c), 32'(bus.req_ready), 0);
      chk($sformatf("stall.rv%0d", c), 32'(bus.resp_valid), 32'(c < 3));
      chk($sformatf("stall.busy%0d", c), 32'(busy), 32'(c < 3));
      if (c < 3) begin
        chk($sformatf("stall.rid%0d", c), 32'(bus.resp_id), c);
        chk($sformatf("stall.rdata%0d", c), 32'(bus.resp_data), 32'(ref_log2(op[c])));
      end
      next_cyc();
    end
    en = 1'b1;
    @(negedge clk);
    chk("stall.resume", 32'(bus.req_ready), 32'h8);
    next_cyc();
    bus.req_valid = '0;
    repeat (LAT + 1) next_cyc();

    // Reset with three in flight
    do_reset();
    bus.req_valid = 4'hF;
    repeat (3) next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.ready", 32'(bus.req_ready), 0);
    chk("mrst.rv", 32'(bus.resp_valid), 0);
    next_cyc();
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (t == 1) chk("mrst.lowest", 32'(bus.req_ready), 32'h2);
      chk($sformatf("mrst.rv%0d", t), 32'(bus.resp_valid), 32'(t == 4));
      if (t == 4) chk("mrst.rid", 32'(bus.resp_id), 1);
      next_cyc();
      bus.req_valid = '0;
    end

    // Zero and tiny operands both map to 8'h00
    do_reset();
    bus.req_data[0] = 24'h000000;
    bus.req_data[1] = 24'h000100;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("zero.g0", 32'(bus.req_ready), 32'h1);
    next_cyc();
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("zero.g1", 32'(bus.req_ready), 32'h2);
    next_cyc();
    bus.req_valid = '0;
    next_cyc();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      chk($sformatf("zero.rv%0d", t), 32'(bus.resp_valid), 1);
      chk($sformatf("zero.rid%0d", t), 32'(bus.resp_id), t);
      chk($sformatf("zero.rdata%0d", t), 32'(bus.resp_data), 0);
`ifdef LOG2_ARB_ZERO_FLAG_EN
      chk($sformatf("zero.flag%0d", t), 32'(bus.resp_zero), 32'(t == 0));
`endif
      next_cyc();
    end
    @(negedge clk);
`ifdef LOG2_ARB_ZERO_FLAG_EN
    chk("zero.idle", 32'(bus.resp_zero), 0);
`endif
    chk("zero.idle_rv", 32'(bus.resp_valid), 0);
    next_cyc();

    // Random traffic against a round-robin reference
    do_reset();
    run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
